// File: rtl/mips_cpu_ir_queue_if.sv
// Handshake and decoded-field bundle between the instruction fetch path and decode.
// The master side feeds words and consumes the head; the slave side is the queue.
interface mips_cpu_ir_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic [31:0]                mem_input;
  logic                       in_valid;
  logic                       in_ready;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  logic [5:0]                 op;
  logic [4:0]                 rs;
  logic [4:0]                 rt;
  logic [4:0]                 rd;
  logic [4:0]                 shift;
  logic [5:0]                 func;
  logic [15:0]                i;
  logic [25:0]                mem_address;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output mem_input, in_valid, flush, out_ready,
    input  in_ready, out_valid, op, rs, rt, rd, shift, func, i, mem_address, count
  );

  modport slave (
    input  mem_input, in_valid, flush, out_ready,
    output in_ready, out_valid, op, rs, rt, rd, shift, func, i, mem_address, count
  );
endinterface

// File: rtl/mips_cpu_ir_queue.sv
// Instruction-register queue: circular buffer of fetched words with valid/ready on both
// sides, optional empty-queue bypass, and a one-cycle flush for branch/jump redirects.
module mips_cpu_ir_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter bit          BYPASS = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mips_cpu_ir_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        empty;
  logic        full;
  logic        bypass_en;
  logic        push;
  logic        pop_store;
  logic [31:0] head;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == DepthC);
    bypass_en = BYPASS && empty && bus.in_valid && !bus.flush;

    bus.in_ready  = !full && !bus.flush;
    bus.out_valid = !empty || bypass_en;

    // A bypassed word that decode takes in the same cycle never touches storage.
    push      = bus.in_valid && bus.in_ready && !(bypass_en && bus.out_ready);
    pop_store = !empty && bus.out_ready && !bus.flush;

    if (!empty) begin
      head = mem_q[rd_ptr_q];
    end else if (bypass_en) begin
      head = bus.mem_input;
    end else begin
      head = '0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_store) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop_store})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem_q[wr_ptr_q] <= bus.mem_input;
    end
  end

  always_comb begin
    bus.op          = head[31:26];
    bus.rs          = head[25:21];
    bus.rt          = head[20:16];
    bus.rd          = head[15:11];
    bus.shift       = head[10:6];
    bus.func        = head[5:0];
    bus.i           = head[15:0];
    bus.mem_address = head[25:0];
    bus.count       = count_q;
  end

endmodule

// File: doc/mips_cpu_ir_queue.md
# mips_cpu_ir_queue

Parametrised instruction-register queue for the MIPS CPU. It buffers up to DEPTH fetched instruction words between the memory interface and decode, using a valid/ready handshake on both sides. It presents the MIPS fields of the head word (op, rs, rt, rd, shift, func, immediate, jump target). An optional empty-queue bypass and a single-cycle flush for branch/jump redirects are provided.

## Interface
- DEPTH, 4: number of stored instruction words; power of two, ≥2.
- BYPASS, 1: 1 = when the queue is empty, an incoming word is presented combinationally on the outputs in the same cycle; 0 = every word is registered first.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- mem_input  in  32  instruction word from memory.
- in_valid  in  1  mem_input holds a word to enqueue.
- in_ready  out  1  queue accepts a word this cycle.
- flush  in  1  discard all queued words (branch/jump redirect).
- out_valid  out  1  head fields below are valid.
- out_ready  in  1  decode consumes the head word this cycle.
- op  out  6  head[31:26].
- rs  out  5  head[25:21].
- rt  out  5  head[20:16].
- rd  out  5  head[15:11].
- shift  out  5  head[10:6].
- func  out  6  head[5:0].
- i  out  16  head[15:0].
- mem_address  out  26  head[25:0].
- count  out  $clog2(DEPTH+1)  number of stored words.

## Operation
- Storage is a circular buffer of DEPTH×32 bits with read pointer, write pointer and count. Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
- in_ready = (count < DEPTH) && !flush.
- A push occurs when in_valid && in_ready, except in the bypass-consume case below.
- out_valid = (count > 0) || (BYPASS && in_valid && !flush).
- A pop occurs when out_valid && out_ready.
- Head word selection:
  - If count > 0, the head is the word at the read pointer.
  - Else if BYPASS && in_valid && !flush, the head is mem_input.
  - Otherwise the head is 0.
- All field outputs are slices of the head word. All fields are 0 whenever out_valid = 0.
- Bypass-consume: count == 0, BYPASS = 1, in_valid, out_ready and !flush. The word is delivered straight through and is not written; count stays 0.
- Bypass-hold: same as bypass-consume but with out_ready = 0. The word is pushed, so count becomes 1 next cycle.
- Simultaneous push and pop with count > 0: both pointers advance and count is unchanged.
- Full (count == DEPTH): in_ready = 0, so no push occurs even if a pop happens in the same cycle. A pop still occurs.
- Flush has priority over everything. On the clock edge:
  - read pointer, write pointer and count become 0;
  - no push and no pop take effect;
  - out_valid is forced low for bypass during the flush cycle (stored words still show until the edge).
- Overflow and underflow are impossible by construction. Writes with in_ready = 0 are ignored, and an out_ready with out_valid = 0 is ignored.

## Timing
- Reset assertion, asynchronous: pointers and count = 0 immediately. Consequences:
  - out_valid = 0 and all fields = 0;
  - in_ready = 1, unless flush is high.
  - Storage contents need not be cleared.
- Reset deassertion: first push may occur on the next rising edge.
- Registered latency: a word pushed at edge N is visible on the outputs after edge N (count ≥ 1) when it is the head.
- Bypass latency: 0 cycles; combinational path from mem_input/in_valid to the fields and out_valid.
- in_ready depends only on count and flush, never on out_ready. There is no combinational ready→ready path.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Reset mid-operation discards all stored words. Flush mid-operation discards them at the next edge.

## Test plan
- Reset then idle, with in_valid = 0 → out_valid = 0, count = 0, all fields 0, in_ready = 1.
- BYPASS = 1, empty queue, in_valid = 1, mem_input = 0x012A4020, out_ready = 1 → same cycle: out_valid = 1, op = 0, rs = 9, rt = 10, rd = 8, shift = 0, func = 0x20; next cycle count = 0.
- DEPTH = 4: push 0x8C020004, 0x8C030008, 0x00431020, 0x08000010 with out_ready = 0 → count = 4, in_ready = 0, and a 5th word is dropped. Head op = 0x23, i = 4. Popping four times then yields the same order with wrap correct; the final mem_address is 0x0000010.
- Count = 2, in_valid and out_ready both high for 6 cycles → count stays 2, the output order is FIFO, and the pointers wrap past DEPTH-1.
- Count = 3, flush = 1 together with in_valid = 1 and out_ready = 1 → in_ready = 0 in that cycle; next cycle count = 0 and out_valid = 0 unless a new bypass word is present.
- Count = 2, reset pulsed low mid-cycle → out_valid and count drop to 0 before the next edge; after release, a new push appears as the head.
